// File: rtl/riscv_wb_arbiter.sv
// riscv_wb_arbiter: merges ALU and LSU write-back into one register-file port through an ALU pending queue; operand forwarding is built only when RISCV_WB_FWD_EN is defined
module riscv_wb_arbiter #(
  parameter int BUF_DEPTH = 2,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_we_i,
  input  logic [ADDR_W-1:0] alu_waddr_i,
  input  logic [31:0]       alu_wdata_i,
  output logic              alu_ready_o,
  input  logic              lsu_we_i,
  input  logic [ADDR_W-1:0] lsu_waddr_i,
  input  logic [31:0]       lsu_wdata_i,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [31:0]       rf_wdata_o,
  input  logic [ADDR_W-1:0] fwd_raddr_a_i,
  input  logic [ADDR_W-1:0] fwd_raddr_b_i,
  output logic              fwd_hit_a_o,
  output logic              fwd_hit_b_o,
  output logic [31:0]       fwd_data_a_o,
  output logic [31:0]       fwd_data_b_o,
  output logic              buf_empty_o,
  output logic              lsu_drop_o
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(BUF_DEPTH);
  logic [ADDR_W-1:0] q_addr [BUF_DEPTH];
  logic [31:0] q_data [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] q_valid;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count;
  logic alu_acc, lsu_hit, lsu_drop, lsu_v, q_empty, head_v, pop, direct, enq;
  assign alu_ready_o = count < FULL;
  assign q_empty = count == '0;
  assign buf_empty_o = q_empty;
  assign alu_acc = alu_we_i && alu_ready_o && alu_waddr_i != '0;
  assign lsu_hit = lsu_we_i && lsu_waddr_i != '0;
  assign lsu_drop = lsu_hit && alu_acc && alu_waddr_i == lsu_waddr_i;
  assign lsu_v = lsu_hit && !lsu_drop;
  assign head_v = !q_empty && q_valid[rd_ptr];
  assign pop = !q_empty && !(q_valid[rd_ptr] && lsu_v);
  assign direct = alu_acc && q_empty && !lsu_v;
  assign enq = alu_acc && !direct;
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_o <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      lsu_drop_o <= 1'b0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      q_valid <= '0;
    end else begin
      rf_we_o <= lsu_v || head_v || direct;
      rf_waddr_o <= lsu_v ? lsu_waddr_i : head_v ? q_addr[rd_ptr] : direct ? alu_waddr_i : rf_waddr_o;
      rf_wdata_o <= lsu_v ? lsu_wdata_i : head_v ? q_data[rd_ptr] : direct ? alu_wdata_i : rf_wdata_o;
      lsu_drop_o <= lsu_drop;
      count <= count + (PW+1)'(enq) - (PW+1)'(pop);
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(enq);
      for (int i = 0; i < BUF_DEPTH; i++)
        if (lsu_v && q_addr[i] == lsu_waddr_i) q_valid[i] <= 1'b0;
      if (pop) q_valid[rd_ptr] <= 1'b0;
      if (enq) q_valid[wr_ptr] <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      q_addr[wr_ptr] <= alu_waddr_i;
      q_data[wr_ptr] <= alu_wdata_i;
    end
  end
`ifdef RISCV_WB_FWD_EN
  logic [1:0][ADDR_W-1:0] fwd_raddr;
  logic [1:0] fwd_hit;
  logic [1:0][31:0] fwd_data;
  assign fwd_raddr = {fwd_raddr_b_i, fwd_raddr_a_i};
  assign fwd_hit_a_o = fwd_hit[0];
  assign fwd_hit_b_o = fwd_hit[1];
  assign fwd_data_a_o = fwd_data[0];
  assign fwd_data_b_o = fwd_data[1];
  always_comb begin
    fwd_hit = '0;
    fwd_data = '0;
    for (int p = 0; p < 2; p++) begin
      if (rf_we_o && rf_waddr_o == fwd_raddr[p]) begin
        fwd_hit[p] = 1'b1;
        fwd_data[p] = rf_wdata_o;
      end
      for (int k = 0; k < BUF_DEPTH; k++)
        if (q_valid[rd_ptr + PW'(k)] && q_addr[rd_ptr + PW'(k)] == fwd_raddr[p]) begin
          fwd_hit[p] = 1'b1;
          fwd_data[p] = q_data[rd_ptr + PW'(k)];
        end
      if (lsu_v && lsu_waddr_i == fwd_raddr[p]) begin
        fwd_hit[p] = 1'b1;
        fwd_data[p] = lsu_wdata_i;
      end
      if (alu_acc && alu_waddr_i == fwd_raddr[p]) begin
        fwd_hit[p] = 1'b1;
        fwd_data[p] = alu_wdata_i;
      end
    end
  end
`else
  logic fwd_unused;
  assign fwd_unused = ^{fwd_raddr_a_i, fwd_raddr_b_i};
  assign fwd_hit_a_o = 1'b0;
  assign fwd_hit_b_o = 1'b0;
  assign fwd_data_a_o = '0;
  assign fwd_data_b_o = '0;
`endif
endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// tb_riscv_wb_arbiter: directed self-checking bench for riscv_wb_arbiter with BUF_DEPTH=2
module tb_riscv_wb_arbiter;
`ifdef RISCV_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic alu_we, alu_ready, lsu_we, rf_we, hit_a, hit_b, buf_empty, lsu_drop;
  logic [5:0] alu_waddr, lsu_waddr, rf_waddr, ra, rb;
  logic [31:0] alu_wdata, lsu_wdata, rf_wdata, data_a, data_b;
  int n_vec = 0, n_bad = 0;
  riscv_wb_arbiter #(.BUF_DEPTH(2), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst),
    .alu_we_i(alu_we), .alu_waddr_i(alu_waddr), .alu_wdata_i(alu_wdata), .alu_ready_o(alu_ready),
    .lsu_we_i(lsu_we), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .fwd_raddr_a_i(ra), .fwd_raddr_b_i(rb),
    .fwd_hit_a_o(hit_a), .fwd_hit_b_o(hit_b), .fwd_data_a_o(data_a), .fwd_data_b_o(data_b),
    .buf_empty_o(buf_empty), .lsu_drop_o(lsu_drop)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    alu_we = 1'b0; alu_waddr = '0; alu_wdata = '0;
    lsu_we = 1'b0; lsu_waddr = '0; lsu_wdata = '0;
    ra = '0; rb = '0;
  endtask
  task automatic test_reset();
    idle();
    rst = 1'b1; alu_we = 1'b1; alu_waddr = 6'd3; alu_wdata = 32'h33;
    tick();
    n_vec++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL reset_we1 got %h want 0", rf_we); end
    n_vec++; if (buf_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %h want 1", buf_empty); end
    n_vec++; if (rf_waddr !== 6'd0 || rf_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_rf got %h/%h want 0/0", rf_waddr, rf_wdata); end
    tick();
    n_vec++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL reset_we2 got %h want 0", rf_we); end
    rst = 1'b0; #1;
    n_vec++; if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %h want 1", alu_ready); end
    n_vec++; if (lsu_drop !== 1'b0 || hit_a !== 1'b0 || hit_b !== 1'b0) begin n_bad++; $display("FAIL reset_derived got %h%h%h want 000", lsu_drop, hit_a, hit_b); end
    tick();
    n_vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 6'd3, 32'h33}) begin n_bad++; $display("FAIL reset_first_write got %h/%h/%h want 1/03/00000033", rf_we, rf_waddr, rf_wdata); end
    idle(); tick();
    n_vec++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL reset_idle got %h want 0", rf_we); end
  endtask
  task automatic test_direct();
    idle(); alu_we = 1'b1; alu_waddr = 6'd5; alu_wdata = 32'h11;
    tick(); idle();
    n_vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 6'd5, 32'h11}) begin n_bad++; $display("FAIL direct_write got %h/%h/%h want 1/05/00000011", rf_we, rf_waddr, rf_wdata); end
    n_vec++; if (buf_empty !== 1'b1) begin n_bad++; $display("FAIL direct_empty got %h want 1", buf_empty); end
    tick();
  endtask
  task automatic test_collision_diff();
    idle(); alu_we = 1'b1; alu_waddr = 6'd5; alu_wdata = 32'hA; lsu_we = 1'b1; lsu_waddr = 6'd6; lsu_wdata = 32'hB;
    #1;
    n_vec++; if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL coll_ready got %h want 1", alu_ready); end
    tick(); idle(); ra = 6'd5; #1;
    n_vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 6'd6, 32'hB}) begin n_bad++; $display("FAIL coll_lsu_first got %h/%h/%h want 1/06/0000000b", rf_we, rf_waddr, rf_wdata); end
    n_vec++; if (buf_empty !== 1'b0) begin n_bad++; $display("FAIL coll_queued got %h want 0", buf_empty); end
    n_vec++; if (hit_a !== FWD || data_a !== (FWD ? 32'hA : 32'h0)) begin n_bad++; $display("FAIL coll_fwd_queue got %h/%h want %h/%h", hit_a, data_a, FWD, FWD ? 32'hA : 32'h0); end
    tick();
    n_vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 6'd5, 32'hA}) begin n_bad++; $display("FAIL coll_alu_second got %h/%h/%h want 1/05/0000000a", rf_we, rf_waddr, rf_wdata); end
    n_vec++; if (buf_empty !== 1'b1) begin n_bad++; $display("FAIL coll_drained got %h want 1", buf_empty); end
    n_vec++; if (hit_a !== FWD || data_a !== (FWD ? 32'hA : 32'h0)) begin n_bad++; $display("FAIL coll_fwd_rf got %h/%h want %h/%h", hit_a, data_a, FWD, FWD ? 32'hA : 32'h0); end
    tick();
    n_vec++; if (rf_we !== 1'b0 || hit_a !== 1'b0) begin n_bad++; $display("FAIL coll_quiet got %h/%h want 0/0", rf_we, hit_a); end
  endtask
  task automatic test_collision_same();
    idle(); alu_we = 1'b1; alu_waddr = 6'd7; alu_wdata = 32'h1; lsu_we = 1'b1; lsu_waddr = 6'd7; lsu_wdata = 32'h2;
    tick(); idle();
    n_vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 6'd7, 32'h1}) begin n_bad++; $display("FAIL same_alu_wins got %h/%h/%h want 1/07/00000001", rf_we, rf_waddr, rf_wdata); end
    n_vec++; if (lsu_drop !== 1'b1) begin n_bad++; $display("FAIL same_drop_pulse got %h want 1", lsu_drop); end
    tick();
    n_vec++; if (rf_we !== 1'b0 || lsu_drop !== 1'b0) begin n_bad++; $display("FAIL same_after got %h/%h want 0/0", rf_we, lsu_drop); end
  endtask
  task automatic test_full_queue();
    idle(); alu_we = 1'b1; alu_waddr = 6'd8; alu_wdata = 32'h80; lsu_we = 1'b1; lsu_waddr = 6'd20; lsu_wdata = 32'h1;
    tick();
    alu_waddr = 6'd9; alu_wdata = 32'h90; lsu_waddr = 6'd21; lsu_wdata = 32'h2;
    tick();
    alu_waddr = 6'd10; alu_wdata = 32'hA0; lsu_waddr = 6'd22; lsu_wdata = 32'h3; ra = 6'd9; #1;
    n_vec++; if (alu_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got %h want 0", alu_ready); end
    n_vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 6'd21, 32'h2}) begin n_bad++; $display("FAIL full_lsu21 got %h/%h/%h want 1/15/00000002", rf_we, rf_waddr, rf_wdata); end
    n_vec++; if (hit_a !== FWD || data_a !== (FWD ? 32'h90 : 32'h0)) begin n_bad++; $display("FAIL full_fwd_x9 got %h/%h want %h/%h", hit_a, data_a, FWD, FWD ? 32'h90 : 32'h0); end
    tick();
    lsu_waddr = 6'd9; lsu_wdata = 32'h99; #1;
    n_vec++; if (alu_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready2 got %h want 0", alu_ready); end
    n_vec++; if ({rf_waddr, rf_wdata} !== {6'd22, 32'h3}) begin n_bad++; $display("FAIL full_lsu22 got %h/%h want 16/00000003", rf_waddr, rf_wdata); end
    n_vec++; if (hit_a !== FWD || data_a !== (FWD ? 32'h99 : 32'h0)) begin n_bad++; $display("FAIL full_fwd_lsu got %h/%h want %h/%h", hit_a, data_a, FWD, FWD ? 32'h99 : 32'h0); end
    tick();
    lsu_we = 1'b0; #1;
    n_vec++; if (alu_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready3 got %h want 0", alu_ready); end
    n_vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 6'd9, 32'h99}) begin n_bad++; $display("FAIL full_load_x9 got %h/%h/%h want 1/09/00000099", rf_we, rf_waddr, rf_wdata); end
    n_vec++; if (hit_a !== FWD || data_a !== (FWD ? 32'h99 : 32'h0)) begin n_bad++; $display("FAIL full_fwd_stale got %h/%h want %h/%h", hit_a, data_a, FWD, FWD ? 32'h99 : 32'h0); end
    tick();
    n_vec++; if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_back got %h want 1", alu_ready); end
    n_vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 6'd8, 32'h80}) begin n_bad++; $display("FAIL full_x8 got %h/%h/%h want 1/08/00000080", rf_we, rf_waddr, rf_wdata); end
    tick(); idle();
    n_vec++; if (rf_we !== 1'b0 || buf_empty !== 1'b0) begin n_bad++; $display("FAIL full_skip_x9 got %h/%h want 0/0", rf_we, buf_empty); end
    tick();
    n_vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 6'd10, 32'hA0}) begin n_bad++; $display("FAIL full_x10 got %h/%h/%h want 1/0a/000000a0", rf_we, rf_waddr, rf_wdata); end
    n_vec++; if (buf_empty !== 1'b1) begin n_bad++; $display("FAIL full_drained got %h want 1", buf_empty); end
    tick();
  endtask
  task automatic test_addr_zero();
    idle(); alu_we = 1'b1; alu_waddr = 6'd0; alu_wdata = 32'hFF; lsu_we = 1'b1; lsu_waddr = 6'd0; lsu_wdata = 32'hEE; #1;
    n_vec++; if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL zero_ready got %h want 1", alu_ready); end
    n_vec++; if (hit_a !== 1'b0 || data_a !== 32'h0) begin n_bad++; $display("FAIL zero_fwd got %h/%h want 0/0", hit_a, data_a); end
    tick(); idle();
    n_vec++; if (rf_we !== 1'b0 || buf_empty !== 1'b1 || lsu_drop !== 1'b0) begin n_bad++; $display("FAIL zero_discard got %h/%h/%h want 0/1/0", rf_we, buf_empty, lsu_drop); end
  endtask
  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      idle(); alu_we = 1'b1; alu_waddr = 6'(i); alu_wdata = 32'h100 + 32'(i); ra = 6'(i); rb = 6'(i - 1); #1;
      n_vec++; if (hit_a !== FWD || data_a !== (FWD ? 32'h100 + 32'(i) : 32'h0)) begin n_bad++; $display("FAIL b2b_fwd_alu%0d got %h/%h want %h", i, hit_a, data_a, FWD); end
      if (i > 1) begin
        n_vec++; if (hit_b !== FWD || data_b !== (FWD ? 32'hFF + 32'(i) : 32'h0)) begin n_bad++; $display("FAIL b2b_fwd_rf%0d got %h/%h want %h", i, hit_b, data_b, FWD); end
      end
      tick();
      n_vec++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 6'(i), 32'h100 + 32'(i)}) begin n_bad++; $display("FAIL b2b_write%0d got %h/%h/%h", i, rf_we, rf_waddr, rf_wdata); end
    end
    idle(); tick();
    n_vec++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got %h want 0", rf_we); end
  endtask
  task automatic test_reset_flush();
    idle(); alu_we = 1'b1; alu_waddr = 6'd11; alu_wdata = 32'h1; lsu_we = 1'b1; lsu_waddr = 6'd12; lsu_wdata = 32'h2;
    tick(); idle(); rst = 1'b1;
    tick(); rst = 1'b0; #1;
    n_vec++; if (buf_empty !== 1'b1 || rf_we !== 1'b0) begin n_bad++; $display("FAIL flush_state got %h/%h want 1/0", buf_empty, rf_we); end
    tick();
    n_vec++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL flush_lost got %h want 0", rf_we); end
  endtask
  initial begin
    test_reset();
    test_direct();
    test_collision_diff();
    test_collision_same();
    test_full_queue();
    test_addr_zero();
    test_back_to_back();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
